// File: rtl/vslc_scan_engine_if.sv
// Bus bundle for the vslc_scan_engine: run/program-load controls, I/O points and status.
interface vslc_scan_engine_if #(
  parameter int N_IO = 16,
  parameter int PC_W = 5
);
  logic            run;
  logic            prog_we;
  logic [3:0]      prog_data;
  logic [N_IO-1:0] in_bits;
  logic [N_IO-1:0] out_bits;
  logic [PC_W-1:0] pc;
  logic            scan_done;
  logic            fault;

  modport master (
    output run, prog_we, prog_data, in_bits,
    input  out_bits, pc, scan_done, fault
  );

  modport slave (
    input  run, prog_we, prog_data, in_bits,
    output out_bits, pc, scan_done, fault
  );
endinterface

// File: rtl/vslc_scan_engine.sv
// Nibble-coded bit-stack scan engine (PLC-style cyclic program over input/output points).
// Optional macro VSLC_SCAN_IMAGE_EN: scan-synchronous input/output images instead of live I/O.
module vslc_scan_engine #(
  parameter int CODE_DEPTH  = 32,
  parameter int STACK_DEPTH = 16,
  parameter int N_IO        = 16
) (
  input logic               clk,
  input logic               rst_n,
  vslc_scan_engine_if.slave bus
);
  localparam int PC_W = $clog2(CODE_DEPTH);
  localparam int DW   = $clog2(STACK_DEPTH + 1);
  localparam logic [PC_W-1:0] LAST = PC_W'(CODE_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, OPERAND} state_t;

  state_t                 state;
  logic [3:0]             code [CODE_DEPTH];
  logic [PC_W-1:0]        pc_q, load_ptr;
  logic [3:0]             op_q, nib, opc, opnd;
  logic [STACK_DEPTH-1:0] stk, stk1, stk_n;
  logic [DW-1:0]          depth, d1, depth_n;
  logic [N_IO-1:0]        out_q;
  logic                   scan_done_q, fault_q;
  logic [15:0]            in_view, out_base, out_n;
  logic [1:0]             need, pops;
  logic                   exec, push, pval, top, nxt, under, over, fault_set, end_now;

`ifdef VSLC_SCAN_IMAGE_EN
  logic [N_IO-1:0] in_img, shadow;
  assign in_view  = 16'(in_img);
  assign out_base = 16'(shadow);
`else
  assign in_view  = 16'(bus.in_bits);
  assign out_base = 16'(out_q);
`endif

  assign nib           = code[pc_q];
  assign bus.out_bits  = out_q;
  assign bus.pc        = pc_q;
  assign bus.scan_done = scan_done_q;
  assign bus.fault     = fault_q;

  assign end_now = (state == FETCH && (nib == 4'd7 || pc_q == LAST)) ||
                   (state == OPERAND && pc_q == LAST);

  always_ff @(posedge clk) begin
    if (rst_n && !bus.run && state == IDLE && bus.prog_we)
      code[load_ptr] <= bus.prog_data;
  end

  // Two-nibble ops execute in OPERAND; an operand opcode fetched at the last address never executes.
  always_comb begin
    exec  = 1'b0;
    opc   = op_q;
    opnd  = nib;
    need  = 2'd0;
    pops  = 2'd0;
    push  = 1'b0;
    pval  = 1'b0;
    out_n = out_base;
    top   = stk[0];
    nxt   = stk[1];
    if (state == FETCH && nib > 4'd3) begin
      exec = 1'b1;
      opc  = nib;
    end else if (state == OPERAND) begin
      exec = 1'b1;
    end
    case (opc)
      4'd0:  begin push = 1'b1; pval = in_view[opnd]; end
      4'd1:  begin need = 2'd1; pops = 2'd1; out_n[opnd] = top; end
      4'd2:  begin need = 2'd1; pops = 2'd1; if (top) out_n[opnd] = 1'b1; end
      4'd3:  begin need = 2'd1; pops = 2'd1; if (top) out_n[opnd] = 1'b0; end
      4'd4:  begin need = 2'd1; push = 1'b1; pval = top; end
      4'd5:  begin need = 2'd1; pops = 2'd1; end
      4'd6:  begin push = 1'b1; pval = 1'b1; end
      4'd8:  begin need = 2'd1; pops = 2'd1; push = 1'b1; pval = ~top; end
      4'd9:  begin need = 2'd2; pops = 2'd2; push = 1'b1; pval = top & nxt; end
      4'd10: begin need = 2'd2; pops = 2'd2; push = 1'b1; pval = top | nxt; end
      4'd11: begin need = 2'd2; pops = 2'd2; push = 1'b1; pval = top ^ nxt; end
      4'd12: begin need = 2'd2; pops = 2'd2; push = 1'b1; pval = ~top | nxt; end
      4'd13: begin need = 2'd2; pops = 2'd2; push = 1'b1; pval = ~(top ^ nxt); end
      4'd14: begin need = 2'd2; pops = 2'd2; push = 1'b1; pval = ~(top & nxt); end
      default: ;
    endcase
    // Bits above the current depth are always zero, so underflow reads return 0 for free.
    under   = depth < DW'(need);
    d1      = under ? '0 : depth - DW'(pops);
    stk1    = stk >> pops;
    over    = push && (d1 == DW'(STACK_DEPTH));
    stk_n   = stk1;
    depth_n = d1;
    if (push && !over) begin
      stk_n   = {stk1[STACK_DEPTH-2:0], pval};
      depth_n = d1 + 1'b1;
    end
    fault_set = exec && (under || over);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_q        <= '0;
      load_ptr    <= '0;
      op_q        <= '0;
      stk         <= '0;
      depth       <= '0;
      out_q       <= '0;
      scan_done_q <= 1'b0;
      fault_q     <= 1'b0;
`ifdef VSLC_SCAN_IMAGE_EN
      in_img      <= '0;
      shadow      <= '0;
`endif
    end else if (!bus.run) begin
      state       <= IDLE;
      pc_q        <= '0;
      stk         <= '0;
      depth       <= '0;
      scan_done_q <= 1'b0;
      // Leaving a non-IDLE state with run low is exactly the run 1->0 transition.
      if (state != IDLE)
        load_ptr <= '0;
      else if (bus.prog_we)
        load_ptr <= load_ptr + 1'b1;
    end else begin
      scan_done_q <= 1'b0;
`ifdef VSLC_SCAN_IMAGE_EN
      if (state == IDLE || scan_done_q)
        in_img <= bus.in_bits;
      if (scan_done_q)
        out_q <= shadow;
`endif
      if (state == IDLE) begin
        state <= FETCH;
      end else begin
        if (exec) begin
          stk   <= stk_n;
          depth <= depth_n;
          if (fault_set)
            fault_q <= 1'b1;
`ifdef VSLC_SCAN_IMAGE_EN
          shadow <= out_n[N_IO-1:0];
`else
          out_q  <= out_n[N_IO-1:0];
`endif
        end
        if (state == FETCH)
          op_q <= nib;
        if (end_now) begin
          pc_q        <= '0;
          stk         <= '0;
          depth       <= '0;
          scan_done_q <= 1'b1;
          state       <= FETCH;
        end else begin
          pc_q  <= pc_q + 1'b1;
          state <= (state == FETCH && nib < 4'd4) ? OPERAND : FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_vslc_scan_engine.sv
// Self-checking bench for vslc_scan_engine (default build): instruction-level reference model,
// directed programs plus randomized programs and inputs.
module tb_vslc_scan_engine;
  localparam int CD  = 32;
  localparam int SD  = 16;
  localparam int NIO = 16;
  localparam int PCW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vslc_scan_engine_if #(.N_IO(NIO), .PC_W(PCW)) bus();

  vslc_scan_engine #(.CODE_DEPTH(CD), .STACK_DEPTH(SD), .N_IO(NIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int failures = 0;

  int          code_m [CD];
  logic [15:0] exp_out;
  logic        exp_fault;
  int          exp_cycles;
  bit          stk_q [$];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_pop();
    if (stk_q.size() == 0) begin
      exp_fault = 1'b1;
      return 1'b0;
    end
    return stk_q.pop_back();
  endfunction

  function automatic void m_push(input bit b);
    if (stk_q.size() >= SD) exp_fault = 1'b1;
    else stk_q.push_back(b);
  endfunction

  function automatic void m_exec(input int op, input int n, input logic [15:0] inb);
    bit a, b;
    case (op)
      0: m_push((n < NIO) ? inb[n] : 1'b0);
      1: begin a = m_pop(); if (n < NIO) exp_out[n] = a; end
      2: begin a = m_pop(); if (a && n < NIO) exp_out[n] = 1'b1; end
      3: begin a = m_pop(); if (a && n < NIO) exp_out[n] = 1'b0; end
      4: begin
        if (stk_q.size() == 0) begin exp_fault = 1'b1; a = 1'b0; end
        else a = stk_q[stk_q.size()-1];
        m_push(a);
      end
      5: a = m_pop();
      6: m_push(1'b1);
      8: m_push(!m_pop());
      9, 10, 11, 12, 13, 14: begin
        a = m_pop();
        b = m_pop();
        case (op)
          9:  m_push(a & b);
          10: m_push(a | b);
          11: m_push(a ^ b);
          12: m_push(!a | b);
          13: m_push(!(a ^ b));
          default: m_push(!(a & b));
        endcase
      end
      default: ;
    endcase
  endfunction

  // One full scan from address 0 with an empty stack; returns its length in cycles.
  function automatic void model_scan(input logic [15:0] inb);
    int addr = 0;
    int op;
    exp_cycles = 0;
    stk_q.delete();
    while (1) begin
      op = code_m[addr];
      exp_cycles++;
      if (addr == CD - 1) begin
        if (op >= 4) m_exec(op, 0, inb);
        break;
      end
      if (op == 7) break;
      if (op < 4) begin
        addr++;
        exp_cycles++;
        m_exec(op, code_m[addr], inb);
        if (addr == CD - 1) break;
        addr++;
      end else begin
        m_exec(op, 0, inb);
        addr++;
      end
    end
  endfunction

  task automatic apply_stimulus();
    tick();
    for (int i = 0; i < CD; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_data = 4'(code_m[i]);
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  task automatic run_scans(input int nscans, input bit first, input bit rnd);
    int cnt;
    int exp_len;
    for (int s = 0; s < nscans; s++) begin
      if (rnd) bus.in_bits = 16'($urandom);
      model_scan(bus.in_bits);
      exp_len = (first && s == 0) ? exp_cycles + 1 : exp_cycles;
      bus.run = 1'b1;
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!bus.scan_done && cnt < 400);
      check_output("scan_len", 32'(cnt), 32'(exp_len));
      check_output("out_bits", 32'(bus.out_bits), 32'(exp_out));
      check_output("fault", 32'(bus.fault), 32'(exp_fault));
    end
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    exp_out = '0;
    exp_fault = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < CD; i++) code_m[i] = 15;
  endtask

  initial begin
    bus.run = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_data = 4'd0;
    bus.in_bits = '0;
    exp_out = '0;
    exp_fault = 1'b0;
    #2;
    check_output("rst_out", 32'(bus.out_bits), 32'h0);
    check_output("rst_pc", 32'(bus.pc), 32'h0);
    check_output("rst_done", 32'(bus.scan_done), 32'h0);
    check_output("rst_fault", 32'(bus.fault), 32'h0);
    tick();
    rst_n = 1'b1;

    // PUSH3 PUSH5 AND POP2 END
    fill_nop();
    code_m[0] = 0; code_m[1] = 3; code_m[2] = 0; code_m[3] = 5;
    code_m[4] = 9; code_m[5] = 1; code_m[6] = 2; code_m[7] = 7;
    apply_stimulus();
    bus.in_bits = 16'h0028;
    run_scans(3, 1'b1, 1'b0);
    check_output("and_out2", 32'(bus.out_bits[2]), 32'h1);
    bus.in_bits = 16'h0008;
    run_scans(2, 1'b0, 1'b0);
    check_output("and_out2_clr", 32'(bus.out_bits[2]), 32'h0);
    bus.in_bits = 16'h0028;
    run_scans(1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a scan; code must survive.
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_out", 32'(bus.out_bits), 32'h0);
    check_output("mid_rst_pc", 32'(bus.pc), 32'h0);
    check_output("mid_rst_fault", 32'(bus.fault), 32'h0);
    exp_out = '0;
    exp_fault = 1'b0;
    tick();
    rst_n = 1'b1;
    run_scans(2, 1'b1, 1'b0);

    // Reload without reset: load pointer must restart at 0 after run drops.
    bus.run = 1'b0;
    tick();
    fill_nop();
    for (int i = 0; i <= SD; i++) code_m[i] = 6;
    code_m[SD+1] = 7;
    apply_stimulus();
    run_scans(3, 1'b1, 1'b0);
    check_output("ovf_fault", 32'(bus.fault), 32'h1);

    // AND on empty stack, then NOT and POP the result to output 0.
    do_reset();
    fill_nop();
    code_m[0] = 9; code_m[1] = 8; code_m[2] = 1; code_m[3] = 0; code_m[4] = 7;
    apply_stimulus();
    run_scans(2, 1'b1, 1'b0);

    // All NOP: full-length scans and pc wrap.
    do_reset();
    fill_nop();
    apply_stimulus();
    run_scans(1, 1'b1, 1'b0);
    for (int i = 0; i < CD - 1; i++) tick();
    check_output("wrap_pc_last", 32'(bus.pc), 32'(CD - 1));
    tick();
    check_output("wrap_pc_zero", 32'(bus.pc), 32'h0);
    check_output("wrap_done", 32'(bus.scan_done), 32'h1);
    run_scans(1, 1'b0, 1'b0);

    // Operand opcodes straddling the end of code memory.
    bus.run = 1'b0;
    tick();
    code_m[27] = 6; code_m[28] = 1; code_m[29] = 4; code_m[30] = 6; code_m[31] = 2;
    apply_stimulus();
    run_scans(2, 1'b1, 1'b0);

    for (int p = 0; p < 8; p++) begin
      do_reset();
      for (int i = 0; i < CD; i++) code_m[i] = int'($urandom_range(0, 15));
      apply_stimulus();
      run_scans(4, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/vslc_scan_engine.md
VSLC_SCAN_ENGINE -- requirements
Module: vslc_scan_engine

Interface
REQ-001 Parameter CODE_DEPTH, default 32, code memory depth in nibbles; power of two, 8..256.
REQ-002 Parameter STACK_DEPTH, default 16, bit-stack depth, 2..32.
REQ-003 Parameter N_IO, default 16, input and output point count, 1..16.
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 run  in  1  1 = execute program, 0 = halt and load mode.
REQ-007 prog_we  in  1  code-memory write strobe, honoured only while run=0.
REQ-008 prog_data  in  4  nibble written at load pointer.
REQ-009 in_bits  in  N_IO  input points.
REQ-010 out_bits  out  N_IO  output points.
REQ-011 pc  out  clog2(CODE_DEPTH)  current fetch address.
REQ-012 scan_done  out  1  one-cycle pulse at end of each scan.
REQ-013 fault  out  1  sticky stack overflow/underflow flag.

Function
REQ-014 Opcodes: 0 PUSH n, 1 POP n, 2 SET n, 3 RST n (two nibbles, second = operand n); 4 DUP, 5 DROP, 6 PUSH1, 7 END, 8 NOT, 9 AND, 10 OR, 11 XOR, 12 IMPL (~top|next), 13 XNOR, 14 NAND, 15 NOP.
REQ-015 States: IDLE (run=0), FETCH, OPERAND; IDLE->FETCH when run=1; FETCH->OPERAND for opcodes 0-3; OPERAND->FETCH always; any state->IDLE when run=0 (pc=0, stack cleared, partial scan abandoned).
REQ-016 Each state occupies one cycle; pc increments after every FETCH and OPERAND cycle.
REQ-017 PUSH n pushes input n; POP n writes top to output n and pops; SET/RST n set/clear output n only if top=1, then pop.
REQ-018 Binary ops pop two, push result (net depth -1); NOT and 15 leave depth unchanged; DUP +1; DROP -1; PUSH1 pushes constant 1.
REQ-019 Operand n >= N_IO: reads return 0, writes discarded, no fault.
REQ-020 Push at depth STACK_DEPTH: stack unchanged, fault set.
REQ-021 Pop or operand read at insufficient depth: missing bits read as 0, depth saturates at 0, fault set.
REQ-022 End of scan when END executes or FETCH/OPERAND occurs at pc=CODE_DEPTH-1: next pc=0, stack cleared, scan_done=1 for exactly that following cycle.
REQ-023 Operand nibble at address CODE_DEPTH-1 consumed with opcode at CODE_DEPTH-2 ends the scan; opcode 0-3 at CODE_DEPTH-1 ends scan without executing.
REQ-024 In IDLE each prog_we=1 cycle writes prog_data to code[load_ptr], load_ptr increments modulo CODE_DEPTH.
REQ-025 load_ptr clears on run 1->0 transition; prog_we while run=1 ignored.
REQ-026 fault clears only by reset.

Reset
REQ-027 rst_n=0 asynchronously forces out_bits=0, pc=0, scan_done=0, fault=0, stack empty, load_ptr=0, state IDLE.
REQ-028 Code memory contents not cleared by reset.
REQ-029 Execution resumes at pc=0 first posedge after rst_n=1 with run=1.

Configuration
REQ-030 Macro VSLC_SCAN_IMAGE_EN defined: in_bits sampled into input image on the cycle scan_done asserts and on IDLE->FETCH; PUSH reads image; output writes go to shadow image, copied to out_bits on scan_done cycle.
REQ-031 VSLC_SCAN_IMAGE_EN undefined: PUSH reads in_bits live; output writes update out_bits the cycle after OPERAND.

Verification
REQ-032 Load 0,3,0,5,9,1,2,7 (PUSH3 PUSH5 AND POP2 END); in_bits[3]=in_bits[5]=1 -> out_bits[2]=1, scan_done every 8 cycles, fault=0.
REQ-033 Same program, in_bits[5]=0 -> out_bits[2]=0 next scan; with image enabled no change before scan_done.
REQ-034 Program of STACK_DEPTH+1 PUSH1 then END -> fault=1, stays 1 through later scans until rst_n=0.
REQ-035 Program 9 then END on empty stack -> fault=1, result 0 on stack.
REQ-036 Program all NOP -> scan_done every CODE_DEPTH cycles, pc wraps CODE_DEPTH-1 -> 0.
REQ-037 rst_n low mid-scan -> outputs 0 immediately; code retained; run=1 restarts at pc=0.
